// File: rtl/bp_common_pkg.sv
// Shared PMA types: region attributes, region record and access command.
// BP_PMA_LOCK_EN adds a sticky lock bit as the attribute MSB.
package bp_common_pkg;

  localparam int bp_pma_ptag_width_gp = 28;

  typedef enum logic [1:0] {
    e_pma_r = 2'd0,
    e_pma_w = 2'd1,
    e_pma_x = 2'd2
  } bp_pma_cmd_e;

  typedef struct packed {
`ifdef BP_PMA_LOCK_EN
    logic lock;
`endif
    logic en;
    logic uncached;
    logic x;
    logic w;
    logic r;
  } bp_pma_attr_s;

  typedef struct packed {
    logic [bp_pma_ptag_width_gp-1:0] base;
    logic [bp_pma_ptag_width_gp-1:0] limit;
    bp_pma_attr_s                    attr;
  } bp_pma_region_s;

  // Reserved command encoding falls back to a read permission check.
  function automatic logic pma_perm(input bp_pma_attr_s attr, input logic [1:0] cmd);
    if (cmd == e_pma_w)      return attr.w;
    else if (cmd == e_pma_x) return attr.x;
    else                     return attr.r;
  endfunction

endpackage

// File: rtl/bp_pma_region_match.sv
// Single-region inclusive range compare; an inverted range never matches.
module bp_pma_region_match
  import bp_common_pkg::*;
(
  input  logic [bp_pma_ptag_width_gp-1:0] ptag_i,
  input  bp_pma_region_s                  region_i,
  output logic                            hit_o
);

  assign hit_o = region_i.attr.en
               & (region_i.base <= ptag_i)
               & (ptag_i <= region_i.limit);

endmodule

// File: rtl/bp_pma_region_table.sv
// Programmable PMA region table with one registered lookup per cycle.
// Optional BP_PMA_LOCK_EN: per-region lock bit that rejects further writes.
module bp_pma_region_table
  import bp_common_pkg::*;
#(
  parameter int                        num_regions_p   = 8,
  parameter int                        ptag_width_p    = bp_pma_ptag_width_gp,
  parameter int                        io_did_width_p  = 3,
  parameter logic [ptag_width_p-1:0]   dram_base_tag_p = 'h80000,
  localparam int idx_w_lp  = (num_regions_p > 1) ? $clog2(num_regions_p) : 1,
  localparam int attr_w_lp = $bits(bp_pma_attr_s)
)(
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    cfg_w_v_i,
  input  logic [idx_w_lp-1:0]     cfg_idx_i,
  input  logic [ptag_width_p-1:0] cfg_base_i,
  input  logic [ptag_width_p-1:0] cfg_limit_i,
  input  logic [attr_w_lp-1:0]    cfg_attr_i,
  output logic                    cfg_err_o,
  input  logic                    ptag_v_i,
  input  logic [ptag_width_p-1:0] ptag_i,
  input  logic [1:0]              cmd_i,
  output logic                    ptag_ready_o,
  output logic                    v_o,
  input  logic                    yumi_i,
  output logic                    hit_o,
  output logic [idx_w_lp-1:0]     hit_idx_o,
  output logic                    uncached_o,
  output logic                    fault_o
);

  bp_pma_region_s [num_regions_p-1:0] regions_q;
  logic [num_regions_p-1:0]           match;
  logic                               in_range, locked, wr_ok, cfg_err_q;
  logic                               hit_d, uncached_d, fault_d, dflt_uncached;
  logic [idx_w_lp-1:0]                hit_idx_d;
  logic                               v_q, hit_q, uncached_q, fault_q, accept;
  logic [idx_w_lp-1:0]                hit_idx_q;

  for (genvar g = 0; g < num_regions_p; g++) begin : g_match
    bp_pma_region_match u_match (
      .ptag_i   (ptag_i),
      .region_i (regions_q[g]),
      .hit_o    (match[g])
    );
  end

  // Zero-extended compare stays meaningful for power-of-two region counts.
  assign in_range = {1'b0, cfg_idx_i} < (idx_w_lp+1)'(num_regions_p);

  always_comb begin
    locked = 1'b0;
`ifdef BP_PMA_LOCK_EN
    for (int i = 0; i < num_regions_p; i++)
      if (cfg_idx_i == idx_w_lp'(i)) locked = regions_q[i].attr.lock;
`endif
  end

  assign wr_ok = cfg_w_v_i & in_range & ~locked;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      regions_q <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_w_v_i & ~wr_ok;
      for (int i = 0; i < num_regions_p; i++)
        if (wr_ok && cfg_idx_i == idx_w_lp'(i))
          regions_q[i] <= '{base: cfg_base_i, limit: cfg_limit_i,
                            attr: bp_pma_attr_s'(cfg_attr_i)};
    end
  end

  // Lowest set bit wins: scan from the top so the lowest index overwrites last.
  always_comb begin
    hit_idx_d = '0;
    for (int i = num_regions_p - 1; i >= 0; i--)
      if (match[i]) hit_idx_d = idx_w_lp'(i);
  end

  assign hit_d         = |match;
  assign dflt_uncached = (ptag_i < dram_base_tag_p)
                       | (|ptag_i[ptag_width_p-1 -: io_did_width_p]);
  assign uncached_d    = hit_d ? regions_q[hit_idx_d].attr.uncached : dflt_uncached;
  assign fault_d       = hit_d & ~pma_perm(regions_q[hit_idx_d].attr, cmd_i);

  assign ptag_ready_o = ~v_q | yumi_i;
  assign accept       = ptag_v_i & ptag_ready_o;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_q        <= 1'b0;
      hit_q      <= 1'b0;
      hit_idx_q  <= '0;
      uncached_q <= 1'b0;
      fault_q    <= 1'b0;
    end else if (accept) begin
      v_q        <= 1'b1;
      hit_q      <= hit_d;
      hit_idx_q  <= hit_idx_d;
      uncached_q <= uncached_d;
      fault_q    <= fault_d;
    end else if (yumi_i) begin
      v_q        <= 1'b0;
    end
  end

  assign cfg_err_o  = cfg_err_q;
  assign v_o        = v_q;
  assign hit_o      = hit_q;
  assign hit_idx_o  = hit_idx_q;
  assign uncached_o = uncached_q;
  assign fault_o    = fault_q;

endmodule
